// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse receiver: synchronises the pins, deserialises frames, assembles
// 3- or 4-byte packets and integrates scaled motion into a clamped cursor.
module ps2_mouse_tracker #(
  parameter int CANVAS_WIDTH   = 360,
  parameter int CANVAS_HEIGHT  = 720,
  parameter int PACKET_BYTES   = 3,
  parameter int SPEED_SHIFT    = 0,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic                             clk_ps2_raw,
  input  logic                             ps2_data,
  output logic [$clog2(CANVAS_WIDTH)-1:0]  mouse_x,
  output logic [$clog2(CANVAS_HEIGHT)-1:0] mouse_y,
  output logic [8:0]                       mouse_dx,
  output logic [8:0]                       mouse_dy,
  output logic [3:0]                       wheel,
  output logic [2:0]                       buttons,
  output logic                             click,
  output logic                             packet_valid,
  output logic                             frame_error
);
  localparam int XW = $clog2(CANVAS_WIDTH);
  localparam int YW = $clog2(CANVAS_HEIGHT);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d, clk_prev_q, clk_prev_d;
  logic          dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_ok_q, par_ok_d;
  logic [1:0]    idx_q, idx_d;
  logic [6:0]    hdr_q, hdr_d;
  logic [7:0]    b1_q, b1_d, b2_q, b2_d;
  logic [3:0]    wheel_raw_q, wheel_raw_d;
  logic          apply_q, apply_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [8:0]    dx_q, dx_d, dy_q, dy_d;
  logic [3:0]    wheel_q, wheel_d;
  logic [2:0]    buttons_q, buttons_d;
  logic          click_q, click_d, pv_q, pv_d, fe_q, fe_d;

  logic               fall;
  logic [8:0]         dx_pkt, dy_pkt;
  logic signed [12:0] sx, sy;
  logic signed [31:0] x_sum, y_sum;
  logic [XW-1:0]      x_new;
  logic [YW-1:0]      y_new;

  assign fall = clk_prev_q & ~clk_s2_q;

  // hdr_q holds byte 0 without its always-one bit: {yovf, xovf, ysign, xsign, m, r, l}
  always_comb begin
    dx_pkt = {hdr_q[3], b1_q};
    if (hdr_q[5]) dx_pkt = hdr_q[3] ? 9'h100 : 9'h0FF;
    dy_pkt = {hdr_q[4], b2_q};
    if (hdr_q[6]) dy_pkt = hdr_q[4] ? 9'h100 : 9'h0FF;
    sx = $signed({{4{dx_pkt[8]}}, dx_pkt}) <<< SPEED_SHIFT;
    sy = $signed({{4{dy_pkt[8]}}, dy_pkt}) <<< SPEED_SHIFT;
    // Screen y grows downward while PS/2 +y is up, hence the subtraction.
    x_sum = $signed({{(32-XW){1'b0}}, x_q}) + $signed({{19{sx[12]}}, sx});
    y_sum = $signed({{(32-YW){1'b0}}, y_q}) - $signed({{19{sy[12]}}, sy});
    if (x_sum < 0)                      x_new = '0;
    else if (x_sum > CANVAS_WIDTH - 1)  x_new = XW'(CANVAS_WIDTH - 1);
    else                                x_new = x_sum[XW-1:0];
    if (y_sum < 0)                      y_new = '0;
    else if (y_sum > CANVAS_HEIGHT - 1) y_new = YW'(CANVAS_HEIGHT - 1);
    else                                y_new = y_sum[YW-1:0];
  end

  always_comb begin
    clk_s1_d = clk_ps2_raw;  clk_s2_d = clk_s1_q;  clk_prev_d = clk_s2_q;
    dat_s1_d = ps2_data;     dat_s2_d = dat_s1_q;
    state_d = state_q;  bit_cnt_d = bit_cnt_q;  shift_d = shift_q;  par_ok_d = par_ok_q;
    idx_d = idx_q;  hdr_d = hdr_q;  b1_d = b1_q;  b2_d = b2_q;  wheel_raw_d = wheel_raw_q;
    apply_d = 1'b0;  tmo_d = tmo_q;
    x_d = x_q;  y_d = y_q;  dx_d = dx_q;  dy_d = dy_q;  wheel_d = wheel_q;  buttons_d = buttons_q;
    click_d = 1'b0;  pv_d = 1'b0;  fe_d = 1'b0;

    if (fall) begin
      tmo_d = '0;
      case (state_q)
        IDLE: if (!dat_s2_q) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
        DATA: begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_ok_d = ^{shift_q, dat_s2_q};
          state_d  = STOP;
        end
        default: begin
          state_d = IDLE;
          if (!(par_ok_q && dat_s2_q)) begin
            fe_d  = 1'b1;
            idx_d = '0;
          end else begin
            case (idx_q)
              2'd0: begin
                // Bit 3 of a header is always one; anything else means lost sync.
                if (!shift_q[3]) fe_d = 1'b1;
                else begin
                  hdr_d = {shift_q[7:4], shift_q[2:0]};
                  idx_d = 2'd1;
                end
              end
              2'd1: begin
                b1_d  = shift_q;
                idx_d = 2'd2;
              end
              2'd2: begin
                b2_d = shift_q;
                if (PACKET_BYTES == 4) idx_d = 2'd3;
                else begin
                  idx_d   = 2'd0;
                  apply_d = 1'b1;
                end
              end
              default: begin
                wheel_raw_d = shift_q[3:0];
                idx_d       = 2'd0;
                apply_d     = 1'b1;
              end
            endcase
          end
        end
      endcase
    end else if (state_q != IDLE || idx_q != 2'd0) begin
      if (tmo_q >= TW'(TIMEOUT_CYCLES - 1)) begin
        state_d = IDLE;
        idx_d   = '0;
        fe_d    = 1'b1;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end else begin
      tmo_d = '0;
    end

    if (apply_q) begin
      pv_d      = 1'b1;
      dx_d      = dx_pkt;
      dy_d      = dy_pkt;
      wheel_d   = (PACKET_BYTES == 4) ? wheel_raw_q : 4'd0;
      buttons_d = hdr_q[2:0];
      click_d   = hdr_q[0] & ~buttons_q[0];
      x_d       = x_new;
      y_d       = y_new;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      clk_s1_q <= 1'b0;  clk_s2_q <= 1'b0;  clk_prev_q <= 1'b0;
      dat_s1_q <= 1'b0;  dat_s2_q <= 1'b0;
      state_q <= IDLE;  bit_cnt_q <= '0;  shift_q <= '0;  par_ok_q <= 1'b0;
      idx_q <= '0;  hdr_q <= '0;  b1_q <= '0;  b2_q <= '0;  wheel_raw_q <= '0;
      apply_q <= 1'b0;  tmo_q <= '0;
      x_q <= XW'(CANVAS_WIDTH / 2);  y_q <= YW'(CANVAS_HEIGHT / 2);
      dx_q <= '0;  dy_q <= '0;  wheel_q <= '0;  buttons_q <= '0;
      click_q <= 1'b0;  pv_q <= 1'b0;  fe_q <= 1'b0;
    end else begin
      clk_s1_q <= clk_s1_d;  clk_s2_q <= clk_s2_d;  clk_prev_q <= clk_prev_d;
      dat_s1_q <= dat_s1_d;  dat_s2_q <= dat_s2_d;
      state_q <= state_d;  bit_cnt_q <= bit_cnt_d;  shift_q <= shift_d;  par_ok_q <= par_ok_d;
      idx_q <= idx_d;  hdr_q <= hdr_d;  b1_q <= b1_d;  b2_q <= b2_d;  wheel_raw_q <= wheel_raw_d;
      apply_q <= apply_d;  tmo_q <= tmo_d;
      x_q <= x_d;  y_q <= y_d;
      dx_q <= dx_d;  dy_q <= dy_d;  wheel_q <= wheel_d;  buttons_q <= buttons_d;
      click_q <= click_d;  pv_q <= pv_d;  fe_q <= fe_d;
    end
  end

  assign mouse_x      = x_q;
  assign mouse_y      = y_q;
  assign mouse_dx     = dx_q;
  assign mouse_dy     = dy_q;
  assign wheel        = wheel_q;
  assign buttons      = buttons_q;
  assign click        = click_q;
  assign packet_valid = pv_q;
  assign frame_error  = fe_q;
endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Bench for ps2_mouse_tracker: a standard-packet instance driven from a vector
// table plus error/timeout/reset sequences, and a wheel instance with SPEED_SHIFT=1.
module tb_ps2_mouse_tracker;
  localparam int HALF = 15;
  localparam int TMO  = 1000;
  localparam int EW   = 45;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic ps2c_drv = 1'b1, data_drv = 1'b1, sel = 1'b0;
  logic clk_ps2_a, ps2_data_a, clk_ps2_b, ps2_data_b;
  assign clk_ps2_a  = sel ? 1'b1 : ps2c_drv;
  assign ps2_data_a = sel ? 1'b1 : data_drv;
  assign clk_ps2_b  = sel ? ps2c_drv : 1'b1;
  assign ps2_data_b = sel ? data_drv : 1'b1;

  logic [8:0] x_a, x_b, dx_a, dx_b, dy_a, dy_b;
  logic [9:0] y_a, y_b;
  logic [3:0] wheel_a, wheel_b;
  logic [2:0] btn_a, btn_b;
  logic click_a, click_b, pv_a, pv_b, fe_a, fe_b;

  ps2_mouse_tracker #(.TIMEOUT_CYCLES(TMO)) dut_a (
    .clk_in(clk), .rst_in(rst), .clk_ps2_raw(clk_ps2_a), .ps2_data(ps2_data_a),
    .mouse_x(x_a), .mouse_y(y_a), .mouse_dx(dx_a), .mouse_dy(dy_a), .wheel(wheel_a),
    .buttons(btn_a), .click(click_a), .packet_valid(pv_a), .frame_error(fe_a));

  ps2_mouse_tracker #(.PACKET_BYTES(4), .SPEED_SHIFT(1), .TIMEOUT_CYCLES(TMO)) dut_b (
    .clk_in(clk), .rst_in(rst), .clk_ps2_raw(clk_ps2_b), .ps2_data(ps2_data_b),
    .mouse_x(x_b), .mouse_y(y_b), .mouse_dx(dx_b), .mouse_dy(dy_b), .wheel(wheel_b),
    .buttons(btn_b), .click(click_b), .packet_valid(pv_b), .frame_error(fe_b));

  typedef struct {
    logic [7:0] b0, b1, b2;
    logic [8:0] x;
    logic [9:0] y;
    logic [8:0] dx, dy;
    logic [2:0] btn;
    logic       clk;
  } vec_t;
  vec_t vecs[14];

  logic [EW-1:0] exp_a_q[$];
  logic [EW-1:0] exp_b_q[$];
  int n_cmp = 0, n_err = 0;
  int pv_cnt_a = 0, pv_cnt_b = 0, fe_cnt_a = 0, fe_cnt_b = 0, click_cnt_a = 0;
  int n_push_a = 0, n_click_a = 0;
  logic [8:0] last_x;
  logic [9:0] last_y;

  function automatic logic [EW-1:0] pack(input logic [8:0] x, input logic [9:0] y,
      input logic [8:0] dx, input logic [8:0] dy, input logic [3:0] w,
      input logic [2:0] b, input logic c);
    return {x, y, dx, dy, w, b, c};
  endfunction

  task automatic report(input string name, input logic [EW-1:0] act, input logic [EW-1:0] e);
    $display("FAIL %s: got x=%0d y=%0d dx=%h dy=%h w=%h btn=%b click=%b, expected x=%0d y=%0d dx=%h dy=%h w=%h btn=%b click=%b",
             name, act[44:36], act[35:26], act[25:17], act[16:8], act[7:4], act[3:1], act[0],
             e[44:36], e[35:26], e[25:17], e[16:8], e[7:4], e[3:1], e[0]);
  endtask

  // Scoreboard: every packet_valid pulse pops one expected record.
  always @(negedge clk) begin
    logic [EW-1:0] e, act;
    if (fe_a) fe_cnt_a++;
    if (fe_b) fe_cnt_b++;
    if (click_a) click_cnt_a++;
    if (pv_a) begin
      pv_cnt_a++;
      n_cmp++;
      act = pack(x_a, y_a, dx_a, dy_a, wheel_a, btn_a, click_a);
      if (exp_a_q.size() == 0) begin
        n_err++;
        $display("FAIL pkt_a_unexpected: got packet_valid with x=%0d y=%0d, expected none", x_a, y_a);
      end else begin
        e = exp_a_q.pop_front();
        if (act !== e) begin n_err++; report("pkt_a", act, e); end
      end
    end
    if (pv_b) begin
      pv_cnt_b++;
      n_cmp++;
      act = pack(x_b, y_b, dx_b, dy_b, wheel_b, btn_b, click_b);
      if (exp_b_q.size() == 0) begin
        n_err++;
        $display("FAIL pkt_b_unexpected: got packet_valid with x=%0d y=%0d, expected none", x_b, y_b);
      end else begin
        e = exp_b_q.pop_front();
        if (act !== e) begin n_err++; report("pkt_b", act, e); end
      end
    end
  end

  task automatic check(input string name, input int act, input int e);
    n_cmp++;
    if (act != e) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, e);
    end
  endtask

  task automatic ps2_bit(input logic v);
    data_drv = v;
    repeat (HALF) @(negedge clk);
    ps2c_drv = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2c_drv = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic par_flip, input logic stop_v);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ par_flip);
    ps2_bit(stop_v);
    data_drv = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic drain(input string name, input logic use_b);
    for (int i = 0; i < 60; i++) begin
      if ((use_b ? exp_b_q.size() : exp_a_q.size()) == 0) break;
      @(negedge clk);
    end
    n_cmp++;
    if ((use_b ? exp_b_q.size() : exp_a_q.size()) != 0) begin
      n_err++;
      $display("FAIL %s_timeout: got no packet_valid, expected one", name);
      if (use_b) exp_b_q.delete(); else exp_a_q.delete();
    end
  endtask

  task automatic send_pkt_a(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
      input logic [8:0] x, input logic [9:0] y, input logic [8:0] dx, input logic [8:0] dy,
      input logic [2:0] btn, input logic c);
    sel = 1'b0;
    exp_a_q.push_back(pack(x, y, dx, dy, 4'd0, btn, c));
    n_push_a++;
    if (c) n_click_a++;
    last_x = x;
    last_y = y;
    send_byte(b0, 1'b0, 1'b1);
    send_byte(b1, 1'b0, 1'b1);
    send_byte(b2, 1'b0, 1'b1);
    drain("pkt_a", 1'b0);
  endtask

  initial begin
    #(10 * 200000);
    $display("FAIL watchdog: got no end of test, expected finish within 200000 cycles");
    $fatal(1);
  end

  initial begin
    int fe0, pv0;
    vecs[0]  = '{8'h08, 8'h55, 8'hAA, 9'd265, 10'd190, 9'd85,   9'd170,  3'b000, 1'b0};
    vecs[1]  = '{8'h08, 8'hFF, 8'h00, 9'd359, 10'd190, 9'd255,  9'd0,    3'b000, 1'b0};
    vecs[2]  = '{8'h08, 8'hFF, 8'h00, 9'd359, 10'd190, 9'd255,  9'd0,    3'b000, 1'b0};
    vecs[3]  = '{8'h19, 8'h00, 8'h00, 9'd103, 10'd190, 9'h100,  9'd0,    3'b001, 1'b1};
    vecs[4]  = '{8'h19, 8'h00, 8'h00, 9'd0,   10'd190, 9'h100,  9'd0,    3'b001, 1'b0};
    vecs[5]  = '{8'h08, 8'h00, 8'hFF, 9'd0,   10'd0,   9'd0,    9'd255,  3'b000, 1'b0};
    vecs[6]  = '{8'h28, 8'h00, 8'h00, 9'd0,   10'd256, 9'd0,    9'h100,  3'b000, 1'b0};
    vecs[7]  = '{8'h28, 8'h00, 8'h01, 9'd0,   10'd511, 9'd0,    9'h101,  3'b000, 1'b0};
    vecs[8]  = '{8'h28, 8'h00, 8'h00, 9'd0,   10'd719, 9'd0,    9'h100,  3'b000, 1'b0};
    vecs[9]  = '{8'h48, 8'h00, 8'h00, 9'd255, 10'd719, 9'd255,  9'd0,    3'b000, 1'b0};
    vecs[10] = '{8'hD8, 8'h00, 8'h00, 9'd0,   10'd464, 9'h100,  9'd255,  3'b000, 1'b0};
    vecs[11] = '{8'h0E, 8'h10, 8'hF0, 9'd16,  10'd224, 9'd16,   9'd240,  3'b110, 1'b0};
    vecs[12] = '{8'h0F, 8'h00, 8'h00, 9'd16,  10'd224, 9'd0,    9'd0,    3'b111, 1'b1};
    vecs[13] = '{8'h3B, 8'h80, 8'h80, 9'd0,   10'd352, 9'h180,  9'h180,  3'b011, 1'b0};

    // Clock/reset
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_x", int'(x_a), 180);
    check("reset_y", int'(y_a), 360);
    check("reset_dx", int'(dx_a), 0);
    check("reset_dy", int'(dy_a), 0);
    check("reset_buttons", int'(btn_a), 0);
    check("reset_pulses", int'({click_a, pv_a, fe_a}), 0);
    check("reset_b_wheel", int'(wheel_b), 0);

    for (int i = 0; i < 14; i++)
      send_pkt_a(vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].x, vecs[i].y,
                 vecs[i].dx, vecs[i].dy, vecs[i].btn, vecs[i].clk);

    // Bad parity on byte 1: dropped, cursor held, next packet is clean.
    fe0 = fe_cnt_a;
    send_byte(8'h08, 1'b0, 1'b1);
    send_byte(8'h55, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    check("parity_fe", fe_cnt_a - fe0, 1);
    check("parity_hold_x", int'(x_a), int'(last_x));
    check("parity_hold_y", int'(y_a), int'(last_y));
    send_pkt_a(8'h08, 8'h05, 8'h03, 9'd5, 10'd349, 9'd5, 9'd3, 3'b000, 1'b0);

    // Bad stop bit on byte 1.
    fe0 = fe_cnt_a;
    send_byte(8'h08, 1'b0, 1'b1);
    send_byte(8'h02, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    check("stop_fe", fe_cnt_a - fe0, 1);
    check("stop_hold_x", int'(x_a), int'(last_x));
    send_pkt_a(8'h08, 8'h02, 8'h00, 9'd7, 10'd349, 9'd2, 9'd0, 3'b000, 1'b0);

    // Header without bit 3 forces resync.
    fe0 = fe_cnt_a;
    send_byte(8'h00, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    check("sync_fe", fe_cnt_a - fe0, 1);
    send_pkt_a(8'h08, 8'h01, 8'h01, 9'd8, 10'd348, 9'd1, 9'd1, 3'b000, 1'b0);

    // One byte then silence: exactly one abandon.
    fe0 = fe_cnt_a;
    send_byte(8'h08, 1'b0, 1'b1);
    repeat (TMO + 10) @(negedge clk);
    check("timeout_fe", fe_cnt_a - fe0, 1);
    check("timeout_hold_y", int'(y_a), int'(last_y));
    send_pkt_a(8'h08, 8'h02, 8'h02, 9'd10, 10'd346, 9'd2, 9'd2, 3'b000, 1'b0);

    // Reset in the middle of a frame.
    fe0 = fe_cnt_a;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    data_drv = 1'b1;
    repeat (5) @(negedge clk);
    check("midreset_fe", fe_cnt_a - fe0, 0);
    check("midreset_x", int'(x_a), 180);
    check("midreset_y", int'(y_a), 360);
    check("midreset_dx", int'(dx_a), 0);
    send_pkt_a(8'h08, 8'h55, 8'hAA, 9'd265, 10'd190, 9'd85, 9'd170, 3'b000, 1'b0);

    // Wheel instance: 4-byte packets, motion doubled.
    fe0 = fe_cnt_a;
    sel = 1'b1;
    exp_b_q.push_back(pack(9'd200, 10'd360, 9'd10, 9'd0, 4'hF, 3'b000, 1'b0));
    send_byte(8'h08, 1'b0, 1'b1);
    send_byte(8'h0A, 1'b0, 1'b1);
    send_byte(8'h00, 1'b0, 1'b1);
    send_byte(8'h0F, 1'b0, 1'b1);
    drain("pkt_b", 1'b1);
    pv0 = pv_cnt_b;
    send_byte(8'h08, 1'b0, 1'b1);
    send_byte(8'h0A, 1'b0, 1'b1);
    send_byte(8'h00, 1'b0, 1'b1);
    repeat (100) @(negedge clk);
    check("b_three_byte_no_pv", pv_cnt_b - pv0, 0);
    repeat (TMO + 10) @(negedge clk);
    check("b_timeout_fe", fe_cnt_b, 1);
    check("b_hold_x", int'(x_b), 200);
    check("a_idle_no_fe", fe_cnt_a - fe0, 0);
    sel = 1'b0;

    // Final report
    repeat (10) @(negedge clk);
    check("a_pv_count", pv_cnt_a, n_push_a);
    check("a_click_count", click_cnt_a, n_click_a);
    check("b_pv_count", pv_cnt_b, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ps2_mouse_tracker.md
Name: ps2_mouse_tracker

Overview:
Parametrised PS/2 mouse receiver and cursor tracker, the successor to the fixed-canvas mouse block. It deserialises PS/2 device-to-host frames and checks parity, stop bit and packet sync. It assembles 3-byte standard or 4-byte IntelliMouse packets and integrates scaled motion into a clamped canvas cursor. It sits between the board PS/2 pins and game logic (card drag/drop, click-to-place).

Parameters:
CANVAS_WIDTH, 360, cursor x range 0..CANVAS_WIDTH-1
CANVAS_HEIGHT, 720, cursor y range 0..CANVAS_HEIGHT-1
PACKET_BYTES, 3, 3 = standard packet, 4 = wheel packet (only 3 or 4 legal)
SPEED_SHIFT, 0, motion deltas arithmetically left-shifted by this amount before integration (0..3)
TIMEOUT_CYCLES, 50000, clk_in cycles without a PS/2 falling edge before a partial frame/packet is abandoned

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous active-high reset
clk_ps2_raw  input  1  asynchronous PS/2 clock from pin
ps2_data  input  1  asynchronous PS/2 data from pin
mouse_x  output  $clog2(CANVAS_WIDTH)  cursor x
mouse_y  output  $clog2(CANVAS_HEIGHT)  cursor y
mouse_dx  output  9  signed x delta of last packet (unscaled)
mouse_dy  output  9  signed y delta of last packet (unscaled)
wheel  output  4  signed wheel delta of last packet (0 when PACKET_BYTES=3)
buttons  output  3  {middle, right, left} of last packet
click  output  1  one-cycle pulse on left-button press
packet_valid  output  1  one-cycle pulse when a packet is applied
frame_error  output  1  one-cycle pulse on any discarded byte/packet

Behaviour:
- Reset values: mouse_x = CANVAS_WIDTH/2, mouse_y = CANVAS_HEIGHT/2; all other outputs 0; byte FSM IDLE; byte index 0; timeout counter 0.
- Reset mid-frame discards all partial state; no frame_error is raised.
- Synchronisation: both pins pass through 2-flop synchronisers. A falling edge is detected as previous synced clock = 1 and current = 0. Data is sampled only on that cycle.
- Byte FSM (IDLE, DATA, PARITY, STOP):
  - IDLE: sampled 0 -> DATA with bit count 0; sampled 1 -> stay in IDLE, no error.
  - DATA: 8 bits, LSB first; after the 8th -> PARITY.
  - PARITY: odd parity over data + parity bit -> STOP.
  - STOP: a byte is accepted only if parity is good and stop = 1. Otherwise frame_error pulses, the byte is dropped and the byte index returns to 0. Always -> IDLE.
- Packet assembly:
  - Byte 0 layout: {yovf, xovf, ysign, xsign, 1, middle, right, left}. If bit3 = 0, the byte is dropped with frame_error and the index stays 0 (resync).
  - dx = {xsign, byte1}; dy = {ysign, byte2}.
  - If xovf/yovf is set, the delta saturates to +255 (sign 0) or -256 (sign 1).
  - In 4-byte mode, wheel = byte3[3:0]; byte3[7:4] is ignored.
- Apply: on the clk_in cycle after the final byte's STOP sample, packet_valid pulses for one cycle. In the same cycle mouse_dx, mouse_dy, wheel and buttons update, the cursor updates, and click = new left & ~old left.
- Arithmetic: sx = dx <<< SPEED_SHIFT in 13-bit signed.
  - x_next = clamp(mouse_x + sx, 0, CANVAS_WIDTH-1).
  - y_next = clamp(mouse_y - sy, 0, CANVAS_HEIGHT-1). PS/2 +y is up; screen +y is down.
  - Intermediates are wide enough that no wrap-around occurs.
- Timeout: the counter resets on every falling edge. If it reaches TIMEOUT_CYCLES while the FSM is not IDLE or the byte index is nonzero, the FSM goes to IDLE, the index goes to 0 and frame_error pulses once. It does not count while fully idle.
- Latency: the final stop-bit edge is seen 3 clk_in cycles after the raw pin edge (2 synchroniser cycles + edge detect); the packet is applied 1 cycle later.
- Button state and cursor change only on packet_valid; errors never move the cursor.

Test Plan:
- Reset -> mouse_x = 180, mouse_y = 360, all pulses 0. Packet 0x08, 0x55, 0xAA with correct parity -> packet_valid once; mouse_dx = 85, mouse_dy = 170, mouse_x = 265, mouse_y = 190; click = 0.
- From reset, two packets 0x08, 0xFF, 0x00 -> mouse_x = 359 after the second (clamped). Then packet 0x19, 0x00, 0x00 -> dx = -256, mouse_x = 103, buttons = 001, click pulses once. An identical repeat -> mouse_x = 0, no click.
- Byte 1 sent with bad parity -> frame_error pulses, cursor unchanged. The next valid 3-byte packet applies normally.
- Byte 0 = 0x00 (bit3 clear) -> frame_error, byte dropped. The following valid packet is accepted as byte 0 onward.
- One valid byte, then ps2 clock held high for TIMEOUT_CYCLES+10 -> exactly one frame_error, index 0. A subsequent full packet applies.
- PACKET_BYTES = 4, SPEED_SHIFT = 1: packet 0x08, 0x0A, 0x00, 0x0F -> wheel = -1, mouse_x = 200, mouse_y = 360. A 3-byte burst alone -> no packet_valid.
